safety_watchdog: RTL and testbench

Windowed watchdog that supervises the host MCU heartbeat and issues an active-low reset request when the heartbeat is late, early, or missing after boot. It is the requesting end of the board reset path: `rst_req_n` feeds the reset generator's `rstn` input, and the generator's filtered, delayed `reset_n` returns to the MCU. All logic runs on one clock. A free-running prescaler converts `clk` cycles into watchdog ticks.

---
 rtl/safety_watchdog.sv | 148 ++++++++++++++
 tb/tb_safety_watchdog.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/safety_watchdog.sv
// Windowed heartbeat watchdog: requests an active-low board reset on a late, early or missing kick.
// Optional early-kick window check is compiled in with `define WDT_WINDOW_EN.
module safety_watchdog #(
  parameter int PRESCALE = 1000,
  parameter int WIN_MIN  = 10,
  parameter int WIN_MAX  = 100,
  parameter int GRACE    = 500,
  parameter int PULSE    = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       kick,
  input  logic       clear_fault,
  output logic       rst_req_n,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [7:0] fault_count,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_GRACE    = 2'd1,
    ST_RUN      = 2'd2,
    ST_FAULT    = 2'd3
  } state_t;

  localparam logic [1:0]  CODE_NONE    = 2'b00;
  localparam logic [1:0]  CODE_TIMEOUT = 2'b01;
  localparam logic [1:0]  CODE_EARLY   = 2'b10;
  localparam logic [15:0] PRESC_LAST   = 16'(PRESCALE - 1);
  localparam logic [15:0] GRACE_LAST   = 16'(GRACE - 1);
  localparam logic [15:0] WIN_LAST     = 16'(WIN_MAX - 1);
  localparam logic [15:0] PULSE_LAST   = 16'(PULSE - 1);

  if (WIN_MAX <= WIN_MIN || WIN_MAX > 65535 || PRESCALE < 2 || PRESCALE > 65535) begin : g_bad_cfg
    $error("safety_watchdog: invalid window or prescaler parameters");
  end

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t      state_q, state_d;
  logic        kick_p0, kick_p1, kick_p2;
  logic        kick_evt, tick;
  logic [15:0] presc_q;
  logic [15:0] tick_cnt;
  logic        kick_ok, fault_entry, early;
  logic [1:0]  code_d;

  // Stage p0/p1: two-flop synchronizer; p2: history flop for edge detect
  always_ff @(posedge clk) begin
    if (reset) begin
      kick_p0 <= 1'b0;
      kick_p1 <= 1'b0;
      kick_p2 <= 1'b0;
      presc_q <= '0;
    end else begin
      kick_p0 <= kick;
      kick_p1 <= kick_p0;
      kick_p2 <= kick_p1;
      presc_q <= (presc_q == PRESC_LAST) ? '0 : presc_q + 16'd1;
    end
  end

  assign kick_evt = kick_p1 & ~kick_p2;
  assign tick     = (presc_q == PRESC_LAST);

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_DISABLED;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    kick_ok     = 1'b0;
    fault_entry = 1'b0;
    code_d      = CODE_NONE;
    early       = 1'b0;
    unique case (state_q)
      ST_DISABLED: begin
        if (en) state_d = ST_GRACE;
      end
      ST_GRACE: begin
        if (!en) begin
          state_d = ST_DISABLED;
        end else if (kick_evt) begin
          state_d = ST_RUN;
        end else if (tick && tick_cnt == GRACE_LAST) begin
          state_d     = ST_FAULT;
          fault_entry = 1'b1;
          code_d      = CODE_TIMEOUT;
        end
      end
      ST_RUN: begin
`ifdef WDT_WINDOW_EN
        early = kick_evt && (tick_cnt < 16'(WIN_MIN));
`else
        early = 1'b0;
`endif
        // An early kick beats a simultaneous en drop; a good kick beats a timeout
        if (early) begin
          state_d     = ST_FAULT;
          fault_entry = 1'b1;
          code_d      = CODE_EARLY;
        end else if (!en) begin
          state_d = ST_DISABLED;
        end else if (kick_evt) begin
          kick_ok = 1'b1;
        end else if (tick && tick_cnt == WIN_LAST) begin
          state_d     = ST_FAULT;
          fault_entry = 1'b1;
          code_d      = CODE_TIMEOUT;
        end
      end
      ST_FAULT: begin
        if (tick && tick_cnt == PULSE_LAST) state_d = en ? ST_GRACE : ST_DISABLED;
      end
      default: state_d = ST_DISABLED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt    <= '0;
      rst_req_n   <= 1'b1;
      fault       <= 1'b0;
      fault_code  <= CODE_NONE;
      fault_count <= '0;
    end else begin
      if (state_d != state_q || kick_ok) tick_cnt <= '0;
      else if (tick)                     tick_cnt <= tick_cnt + 16'd1;
      rst_req_n <= (state_d != ST_FAULT);
      if (fault_entry) begin
        fault       <= 1'b1;
        fault_code  <= code_d;
        fault_count <= sat_inc8(fault_count);
      end else if (clear_fault) begin
        fault <= 1'b0;
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_safety_watchdog.sv
// Directed bench for safety_watchdog with small parameters; times are counted in clk edges since reset release.
module tb_safety_watchdog;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       kick = 1'b0;
  logic       clear_fault = 1'b0;
  logic       rst_req_n;
  logic       fault;
  logic [1:0] fault_code;
  logic [7:0] fault_count;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  safety_watchdog #(
    .PRESCALE(4), .WIN_MIN(2), .WIN_MAX(5), .GRACE(8), .PULSE(3)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .kick(kick), .clear_fault(clear_fault),
    .rst_req_n(rst_req_n), .fault(fault), .fault_code(fault_code),
    .fault_count(fault_count), .state(state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic goto(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic wait_state(input logic [1:0] s, input int lim, input string tag);
    int n = 0;
    while (state !== s && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 16'(state), 16'(s));
  endtask

  // Kick high for 2 cycles then low for the rest of 'total'; counts cycles not in clean RUN
  task automatic kick_pulse(input int total, output int bad);
    bad = 0;
    kick = 1'b1;
    for (int i = 0; i < total; i++) begin
      if (i == 2) kick = 1'b0;
      @(negedge clk);
      if (state !== 2'd2 || rst_req_n !== 1'b1 || fault !== 1'b0) bad++;
    end
    kick = 1'b0;
  endtask

  initial begin
    int r, n, bad, acc, a, x, exp_cnt;
    repeat (3) @(negedge clk);
    chk("rst_state", 16'(state), 16'd0);
    chk("rst_req_n", 16'(rst_req_n), 16'd1);
    chk("rst_fault", 16'(fault), 16'd0);
    chk("rst_code", 16'(fault_code), 16'd0);
    chk("rst_count", 16'(fault_count), 16'd0);

    // Test 1: no kicks, grace timeout. Ticks land on edges r+4k.
    r = cyc;
    reset = 1'b0;
    en = 1'b1;
    @(negedge clk);
    chk("t1_grace", 16'(state), 16'd1);
    goto(r + 31);
    chk("t1_before_timeout", 16'(state), 16'd1);
    goto(r + 32);
    chk("t1_fault_state", 16'(state), 16'd3);
    chk("t1_req_low", 16'(rst_req_n), 16'd0);
    chk("t1_code", 16'(fault_code), 16'd1);
    chk("t1_count", 16'(fault_count), 16'd1);
    chk("t1_fault", 16'(fault), 16'd1);
    exp_cnt = 1;
    goto(r + 43);
    chk("t1_pulse_end_low", 16'(rst_req_n), 16'd0);
    goto(r + 44);
    chk("t1_regrace", 16'(state), 16'd1);
    chk("t1_req_high", 16'(rst_req_n), 16'd1);

    // Test 2: clear_fault, then regular kicks every 3 ticks
    clear_fault = 1'b1;
    @(negedge clk);
    clear_fault = 1'b0;
    chk("t2_cleared", 16'(fault), 16'd0);
    chk("t2_code_kept", 16'(fault_code), 16'd1);
    chk("t2_count_kept", 16'(fault_count), 16'd1);
    kick_pulse(12, bad);
    chk("t2_run", 16'(state), 16'd2);
    acc = 0;
    for (int j = 1; j <= 20; j++) begin
      kick_pulse((j == 20) ? 4 : 12, bad);
      acc += bad;
    end
    chk("t2_run_clean_cycles", 16'(acc), 16'd0);

    // Test 3: kick one tick after the last accepted one
    kick_pulse(6, bad);
`ifdef WDT_WINDOW_EN
    chk("t3_early_state", 16'(state), 16'd3);
    chk("t3_early_code", 16'(fault_code), 16'd2);
    chk("t3_early_req", 16'(rst_req_n), 16'd0);
    chk("t3_early_count", 16'(fault_count), 16'd2);
    exp_cnt = 2;
    wait_state(2'd1, 40, "t3_exit_to_grace");
`else
    chk("t3_nowin_state", 16'(state), 16'd2);
    chk("t3_nowin_code", 16'(fault_code), 16'd1);
    chk("t3_nowin_count", 16'(fault_count), 16'd1);
    chk("t3_nowin_fault", 16'(fault), 16'd0);
`endif
    en = 1'b0;
    @(negedge clk);
    chk("t3_en_drop", 16'(state), 16'd0);

    // Test 4: kick coincident with the timeout tick, then clear_fault coincident with a timeout
    clear_fault = 1'b1;
    @(negedge clk);
    clear_fault = 1'b0;
    chk("t4_cleared", 16'(fault), 16'd0);
    en = 1'b1;
    @(negedge clk);
    n = cyc + 1;
    while ((n - r) % 4 != 2) n++;
    goto(n);
    kick = 1'b1;
    goto(n + 2);
    kick = 1'b0;
    a = n + 3;
    goto(a);
    chk("t4_run", 16'(state), 16'd2);
    goto(a + 16);
    kick = 1'b1;
    goto(a + 18);
    kick = 1'b0;
    x = a + 19;
    goto(x);
    chk("t4_kick_wins_state", 16'(state), 16'd2);
    chk("t4_kick_wins_count", 16'(fault_count), 16'(exp_cnt));
    goto(x + 19);
    chk("t4_pre_timeout", 16'(state), 16'd2);
    clear_fault = 1'b1;
    goto(x + 20);
    clear_fault = 1'b0;
    exp_cnt++;
    chk("t4_timeout_state", 16'(state), 16'd3);
    chk("t4_fault_beats_clear", 16'(fault), 16'd1);
    chk("t4_code", 16'(fault_code), 16'd1);
    chk("t4_count", 16'(fault_count), 16'(exp_cnt));

    // Test 5: en dropped during FAULT, then during RUN
    en = 1'b0;
    goto(x + 31);
    chk("t5_pulse_holds", 16'(state), 16'd3);
    chk("t5_pulse_req", 16'(rst_req_n), 16'd0);
    goto(x + 32);
    chk("t5_fault_to_disabled", 16'(state), 16'd0);
    chk("t5_req_released", 16'(rst_req_n), 16'd1);
    en = 1'b1;
    goto(x + 33);
    kick = 1'b1;
    goto(x + 35);
    kick = 1'b0;
    goto(x + 36);
    chk("t5_run", 16'(state), 16'd2);
    en = 1'b0;
    @(negedge clk);
    chk("t5_run_to_disabled", 16'(state), 16'd0);

    // Test 6: repeated timeouts saturate the counter; reset mid-pulse
    en = 1'b1;
    n = 0;
    while (fault_count !== 8'd255 && n < 15000) begin
      @(negedge clk);
      n++;
    end
    chk("t6_count_255", 16'(fault_count), 16'd255);
    wait_state(2'd1, 60, "t6_back_to_grace");
    wait_state(2'd3, 60, "t6_next_fault");
    chk("t6_count_saturated", 16'(fault_count), 16'd255);
    chk("t6_code", 16'(fault_code), 16'd1);
    repeat (4) @(negedge clk);
    chk("t6_mid_pulse_state", 16'(state), 16'd3);
    chk("t6_mid_pulse_req", 16'(rst_req_n), 16'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_reset_req", 16'(rst_req_n), 16'd1);
    chk("t6_reset_state", 16'(state), 16'd0);
    chk("t6_reset_fault", 16'(fault), 16'd0);
    chk("t6_reset_code", 16'(fault_code), 16'd0);
    chk("t6_reset_count", 16'(fault_count), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
